// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the calculator display path: digit count,
// dash code, default value width and the double-dabble nibble adjust.
package calc_disp_pkg;

   localparam int NUM_DIGITS    = 4;
   localparam int VAL_W_DEFAULT = 14;
   localparam int BCD_W         = 4 * NUM_DIGITS;

   typedef logic [3:0] bcd_nibble_t;

   localparam bcd_nibble_t DIGIT_MINUS = 4'hF;

   // Converter FSM encoding, also visible on the bus for checkers.
   localparam logic [0:0] CONV_IDLE = 1'b0;
   localparam logic [0:0] CONV_RUN  = 1'b1;

   function automatic bcd_nibble_t dd_adjust(input bcd_nibble_t n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between the calculator core (master) and the display scan controller (slave).
// load is a one-cycle strobe sampled with value_in; it is accepted only while busy=0.
interface display_scan_ctrl_if #(parameter int VAL_W = 14);

   logic signed [VAL_W-1:0] value_in;
   logic                    load;
   logic [3:0]              digit;
   logic [3:0]              an;
   logic                    busy;
   logic                    ovf;
   logic [0:0]              conv_state;

   modport master (
      output value_in, load,
      input  digit, an, busy, ovf, conv_state
   );

   modport slave (
      input  value_in, load,
      output digit, an, busy, ovf, conv_state
   );

endinterface

// File: rtl/display_scan_ctrl_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per cycle, VAL_W cycles per value.
// done and bcd are combinational so the final step lands in the caller's register.
module bin2bcd_seq
   import calc_disp_pkg::*;
#(
   parameter int VAL_W = VAL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [VAL_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic [0:0]       state
);

   localparam int CNT_W = $clog2(VAL_W);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj, bcd_sh;
   logic [VAL_W-1:0] bin_q, bin_d, bin_sh;

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bcd_adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
      end
      {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;

      state_d = state_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      if (state_q == CONV_IDLE) begin
         if (start) begin
            state_d = CONV_RUN;
            cnt_d   = '0;
            bcd_d   = '0;
            bin_d   = bin;
         end
      end else begin
         bcd_d = bcd_sh;
         bin_d = bin_sh;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(VAL_W - 1)) begin
            state_d = CONV_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         cnt_q   <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
      end
   end

   assign busy  = (state_q == CONV_RUN);
   assign done  = busy && (cnt_q == CNT_W'(VAL_W - 1));
   assign bcd   = bcd_sh;
   assign state = state_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Display feeder: range-checks a signed value, converts it to BCD, and scans the
// four digits onto a common-anode display with anode and digit registered together.
module display_scan_ctrl
   import calc_disp_pkg::*;
#(
   parameter int VAL_W        = VAL_W_DEFAULT,
   parameter int DIGIT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   display_scan_ctrl_if.slave bus
);

   localparam int REF_W = $clog2(DIGIT_CYCLES);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic signed [VAL_W-1:0] MIN_SHOWN = -999;

   bcd_nibble_t      disp_q [NUM_DIGITS];
   bcd_nibble_t      disp_d [NUM_DIGITS];
   logic             ovf_q, ovf_d;
   logic             neg_q, neg_d;
   logic [REF_W-1:0] ref_q, ref_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   bcd_nibble_t      digit_q, digit_d;

   logic             conv_busy, conv_done, conv_start, accept, too_neg;
   logic [VAL_W-1:0] mag;
   logic [BCD_W-1:0] conv_bcd;

   assign accept     = bus.load && !conv_busy;
   assign too_neg    = $signed(bus.value_in) < MIN_SHOWN;
   assign mag        = bus.value_in[VAL_W-1] ? (~bus.value_in + VAL_W'(1)) : bus.value_in;
   assign conv_start = accept && !too_neg;

   bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (mag),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .state (bus.conv_state)
   );

   always_comb begin
      disp_d = disp_q;
      ovf_d  = ovf_q;
      neg_d  = neg_q;
      if (accept) begin
         if (too_neg) begin
            ovf_d = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] = DIGIT_MINUS;
         end else begin
            ovf_d = 1'b0;
            neg_d = bus.value_in[VAL_W-1];
         end
      end
      // Digits swap in all at once so a half-converted value is never shown.
      if (conv_done) begin
         for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] = conv_bcd[i*4 +: 4];
         if (neg_q) disp_d[NUM_DIGITS-1] = DIGIT_MINUS;
      end

      if (ref_q == REF_W'(DIGIT_CYCLES - 1)) begin
         ref_d = '0;
         idx_d = idx_q + IDX_W'(1);
      end else begin
         ref_d = ref_q + REF_W'(1);
         idx_d = idx_q;
      end
      // Anode and digit come from the same next index so they always agree.
      an_d    = ~(4'b0001 << idx_d);
      digit_d = disp_q[idx_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= '0;
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         an_q    <= 4'b1110;
         digit_q <= '0;
      end else begin
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         neg_q   <= neg_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         digit_q <= digit_d;
      end
   end

   assign bus.digit = digit_q;
   assign bus.an    = an_q;
   assign bus.busy  = conv_busy;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed cases with literal expectations plus random
// loads/resets, all checked every cycle against a transaction-level display model.
module tb_display_scan_ctrl;

   localparam int VW = 14;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   display_scan_ctrl_if #(.VAL_W(VW)) bus ();

   display_scan_ctrl #(.VAL_W(VW), .DIGIT_CYCLES(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_disp;
   logic [15:0] m_pend_disp;
   int          m_pend;
   int          m_t;
   bit          m_valid = 1'b0;
   logic        m_ovf, m_busy;
   logic [3:0]  m_an, m_digit;

   function automatic logic [15:0] digits_of(input int v);
      int m;
      logic [15:0] r;
      m = (v < 0) ? -v : v;
      r = {4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
      if (v < 0) r[15:12] = 4'hF;
      return r;
   endfunction

   always @(posedge clk) begin
      logic [15:0] old;
      bit          was_busy;
      int          sv, idx;
      if (rst) begin
         m_valid = 1'b1;
         m_t = 0; m_disp = '0; m_pend = 0; m_ovf = 1'b0; m_busy = 1'b0;
         m_an = 4'b1110; m_digit = 4'h0;
      end else if (m_valid) begin
         old      = m_disp;
         was_busy = (m_pend > 0);
         m_t++;
         if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) m_disp = m_pend_disp;
         end
         if (bus.load && !was_busy) begin
            sv = bus.value_in;
            if (sv < -999) begin
               m_ovf  = 1'b1;
               m_disp = 16'hFFFF;
            end else begin
               m_ovf       = 1'b0;
               m_pend      = VW;
               m_pend_disp = digits_of(sv);
            end
         end
         m_busy  = (m_pend > 0);
         idx     = (m_t / DC) % 4;
         m_an    = ~(4'b0001 << idx);
         m_digit = old[idx*4 +: 4];
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("an", bus.an, m_an);
         check("digit", bus.digit, m_digit);
         check("busy", bus.busy, m_busy);
         check("ovf", bus.ovf, m_ovf);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_count(input int v, input int exp_len);
      int n;
      @(negedge clk);
      bus.value_in = VW'(v);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_len", n, exp_len);
   endtask

   task automatic check_digits(input logic [15:0] lit);
      repeat (2) @(negedge clk);
      check("model_disp", m_disp, lit);
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.an == ~(4'b0001 << i)) check("lit_digit", bus.digit, lit[i*4 +: 4]);
         end
         @(negedge clk);
      end
   endtask

   logic [3:0] walk [5];

   initial begin
      int n;
      walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      rst = 1'b1;
      bus.load = 1'b0;
      bus.value_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state and anode walk
      check("rst_busy", bus.busy, 1'b0);
      check("rst_ovf", bus.ovf, 1'b0);
      for (int k = 0; k < 20; k++) begin
         check("walk_an", bus.an, walk[k/4]);
         check("walk_digit", bus.digit, 4'h0);
         @(negedge clk);
      end

      load_count(1234, 14);
      check("ovf_1234", bus.ovf, 1'b0);
      check_digits(16'h1234);
      load_count(-42, 14);
      check_digits(16'hF042);
      load_count(-999, 14);
      check_digits(16'hF999);

      // below range: dash display, no conversion
      @(negedge clk);
      bus.value_in = VW'(-1000);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      check("ovf_set", bus.ovf, 1'b1);
      for (int k = 0; k < 5; k++) begin
         check("ovf_no_busy", bus.busy, 1'b0);
         @(negedge clk);
      end
      check_digits(16'hFFFF);
      load_count(7, 14);
      check("ovf_clr", bus.ovf, 1'b0);
      check_digits(16'h0007);

      // load while busy is dropped
      @(negedge clk);
      bus.value_in = VW'(8191);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      n = 0;
      while (bus.busy && n < 100) begin
         if (n == 1) begin
            bus.value_in = VW'(5);
            bus.load     = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      bus.load = 1'b0;
      check("busy_len_8191", n, 14);
      check_digits(16'h8191);

      // reset mid-conversion
      @(negedge clk);
      bus.value_in = VW'(5678);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_an", bus.an, 4'b1110);
      check("abort_digit", bus.digit, 4'h0);
      check("abort_disp", m_disp, 16'h0000);
      load_count(5678, 14);
      check_digits(16'h5678);

      // random traffic
      for (int it = 0; it < 300; it++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         bus.value_in = VW'($urandom_range(0, 16383));
         bus.load     = 1'b1;
         @(negedge clk);
         bus.load = 1'b0;
      end
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
